// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - rasterizer pixel stream to RGB565 framebuffer writer
// Buffers clipped/packed pixels in a FIFO, drives a valid/ready write port, and runs full-frame clears.

module fb_pixel_writer #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        px,
  input  logic [7:0]        py,
  input  logic [23:0]       pixel_color,
  input  logic              pixel_valid,
  input  logic              done,
  input  logic              clear_start,
  input  logic [23:0]       clear_color,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              shape_done,
  output logic              clear_done,
  output logic              overflow,
  output logic [15:0]       clip_count
);

  localparam int              PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);
  localparam logic [8:0]      FB_W9     = 9'(FB_W);
  localparam logic [8:0]      FB_H9     = 9'(FB_H);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_CLEAR  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;
  logic                pending_q, pending_d;
  logic                shape_done_q, shape_done_d;
  logic                clear_done_q, clear_done_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         clip_q, clip_d;

  logic [ADDR_W+15:0]  fifo_mem [FIFO_DEPTH];
  logic [ADDR_W+15:0]  head;

  logic [ADDR_W-1:0]   pix_addr;
  logic [15:0]         pix_data;
  logic [15:0]         clr_data;
  logic                off_screen;
  logic                hs;
  logic                in_clear;
  logic                clear_acc;
  logic                pix_ok;
  logic                want_push;
  logic                push;
  logic                load;
  logic                drop;
  logic [PTR_W:0]      occupancy;
  logic                blk_empty_d;
  logic                shape_open;
  logic                unused_color_bits;

  // Address arithmetic wraps at ADDR_W bits; on-screen addresses always fit.
  assign pix_addr   = ADDR_W'(py) * ADDR_W'(FB_W) + ADDR_W'(px);
  assign pix_data   = {pixel_color[23:19], pixel_color[15:10], pixel_color[7:3]};
  assign clr_data   = {clear_color[23:19], clear_color[15:10], clear_color[7:3]};
  assign unused_color_bits = ^{pixel_color[18:16], pixel_color[9:8], pixel_color[2:0],
                               clear_color[18:16], clear_color[9:8], clear_color[2:0]};

  assign off_screen = ({1'b0, px} >= FB_W9) || ({1'b0, py} >= FB_H9);
  assign hs         = mem_we_q && mem_ready;
  assign in_clear   = (state_q == S_CLEAR);
  assign clear_acc  = (state_q == S_IDLE) && !pending_q && clear_start;
  assign pix_ok     = !in_clear && !clear_acc;
  assign want_push  = pixel_valid && pix_ok && !off_screen;

  // Occupancy includes the entry on the memory port; a completing write frees its slot this cycle.
  assign occupancy  = fifo_cnt_q + {{PTR_W{1'b0}}, mem_we_q};
  assign push       = want_push && ((occupancy != DEPTH_C) || hs);
  assign drop       = (want_push && !push) || (pixel_valid && !pix_ok);
  assign load       = !in_clear && (fifo_cnt_q != '0) && (!mem_we_q || mem_ready);
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    fifo_cnt_d   = fifo_cnt_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, load};
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = load ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pending_d    = pending_q;
    shape_done_d = 1'b0;
    clear_done_d = 1'b0;
    overflow_d   = clear_acc ? 1'b0 : overflow_q;
    clip_d       = clip_q;
    blk_empty_d  = 1'b0;
    shape_open   = 1'b0;

    if (drop) overflow_d = 1'b1;
    if (pixel_valid && pix_ok && off_screen && (clip_q != 16'hFFFF)) clip_d = clip_q + 16'd1;

    case (state_q)
      S_CLEAR: begin
        if (hs) begin
          if (mem_addr_q == LAST_ADDR) begin
            mem_we_d     = 1'b0;
            state_d      = S_IDLE;
            clear_done_d = 1'b1;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        if (clear_acc) begin
          state_d     = S_CLEAR;
          mem_we_d    = 1'b1;
          mem_addr_d  = '0;
          mem_wdata_d = clr_data;
        end else begin
          if (load) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = head[ADDR_W+15:16];
            mem_wdata_d = head[15:0];
          end else if (hs) begin
            mem_we_d = 1'b0;
          end
          blk_empty_d  = (fifo_cnt_d == '0) && !mem_we_d;
          shape_open   = pending_q || done;
          shape_done_d = shape_open && blk_empty_d;
          pending_d    = shape_open && !blk_empty_d;
          state_d      = blk_empty_d ? S_IDLE : S_STREAM;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fifo_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      pending_q    <= 1'b0;
      shape_done_q <= 1'b0;
      clear_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      clip_q       <= '0;
    end else begin
      state_q      <= state_d;
      fifo_cnt_q   <= fifo_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      pending_q    <= pending_d;
      shape_done_q <= shape_done_d;
      clear_done_q <= clear_done_d;
      overflow_q   <= overflow_d;
      clip_q       <= clip_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {pix_addr, pix_data};
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign busy       = (state_q != S_IDLE) || pending_q;
  assign shape_done = shape_done_q;
  assign clear_done = clear_done_q;
  assign overflow   = overflow_q;
  assign clip_count = clip_q;

endmodule
